// File: rtl/arti_pattern_gen_pkg.sv
// Shared raster geometry and pattern-mode encoding for the test-pattern generator.
package arti_pattern_gen_pkg;

  localparam int unsigned H_TOTAL      = 456;
  localparam int unsigned H_ACTIVE     = 384;
  localparam int unsigned HS_START     = 408;
  localparam int unsigned HS_END       = 439;
  localparam int unsigned V_ACTIVE     = 240;
  localparam int unsigned VS_START     = 248;
  localparam int unsigned VS_END       = 250;
  localparam int unsigned V_TOTAL_NTSC = 262;
  localparam int unsigned V_TOTAL_PAL  = 312;
  localparam int unsigned BAND_W       = 48;

  typedef enum logic [1:0] {
    ModeSolid = 2'd0,
    ModeAltA  = 2'd1,
    ModeAltB  = 2'd2,
    ModeBars  = 2'd3
  } mode_e;

endpackage

// File: rtl/arti_pattern_gen_if.sv
// Video output bundle: pixel colour plus blanking and sync strobes.
interface arti_pattern_gen_if;
  logic [7:0] r_out;
  logic [7:0] g_out;
  logic [7:0] b_out;
  logic       hbl_out;
  logic       vbl_out;
  logic       hs_out;
  logic       vs_out;

  modport master (output r_out, g_out, b_out, hbl_out, vbl_out, hs_out, vs_out);
  modport slave  (input  r_out, g_out, b_out, hbl_out, vbl_out, hs_out, vs_out);
endinterface

// File: rtl/arti_pattern_timing.sv
// Raster counters (h, v, band) and combinational sync/blank decode of the current position.
module arti_pattern_timing
  import arti_pattern_gen_pkg::*;
#(
  parameter int unsigned VActive    = V_ACTIVE,
  parameter int unsigned VsStart    = VS_START,
  parameter int unsigned VsEnd      = VS_END,
  parameter int unsigned VTotalNtsc = V_TOTAL_NTSC,
  parameter int unsigned VTotalPal  = V_TOTAL_PAL
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ce_pix_i,
  input  logic pal_i,
  output logic h_lsb_o,
  output logic band_lsb_o,
  output logic line_end_o,
  output logic frame_end_o,
  output logic hbl_o,
  output logic vbl_o,
  output logic hs_o,
  output logic vs_o
);

  localparam logic [8:0] HLast    = 9'(H_TOTAL - 1);
  localparam logic [8:0] HActive  = 9'(H_ACTIVE);
  localparam logic [8:0] HsStart  = 9'(HS_START);
  localparam logic [8:0] HsEnd    = 9'(HS_END);
  localparam logic [8:0] VAct     = 9'(VActive);
  localparam logic [8:0] VsFirst  = 9'(VsStart);
  localparam logic [8:0] VsLast   = 9'(VsEnd);
  localparam logic [5:0] BandLast = 6'(BAND_W - 1);

  logic [8:0] h_q, h_d, v_q, v_d, v_last;
  logic [5:0] sub_q, sub_d;
  logic [2:0] band_q, band_d;
  logic       line_end, frame_end;

  always_comb begin
    v_last    = pal_i ? 9'(VTotalPal - 1) : 9'(VTotalNtsc - 1);
    line_end  = (h_q == HLast);
    frame_end = line_end && (v_q == v_last);
    h_d       = h_q;
    v_d       = v_q;
    sub_d     = sub_q;
    band_d    = band_q;
    if (ce_pix_i) begin
      if (line_end) begin
        h_d    = '0;
        sub_d  = '0;
        band_d = '0;
        v_d    = frame_end ? 9'd0 : v_q + 9'd1;
      end else begin
        h_d = h_q + 9'd1;
        // Band index is a running count of 48-pixel spans, avoiding a divide by 48.
        if (sub_q == BandLast) begin
          sub_d  = '0;
          band_d = band_q + 3'd1;
        end else begin
          sub_d = sub_q + 6'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h_q    <= '0;
      v_q    <= '0;
      sub_q  <= '0;
      band_q <= '0;
    end else begin
      h_q    <= h_d;
      v_q    <= v_d;
      sub_q  <= sub_d;
      band_q <= band_d;
    end
  end

  assign h_lsb_o     = h_q[0];
  assign band_lsb_o  = band_q[0];
  assign line_end_o  = line_end;
  assign frame_end_o = frame_end;
  assign hbl_o       = (h_q >= HActive);
  assign vbl_o       = (v_q >= VAct);
  assign hs_o        = (h_q >= HsStart) && (h_q <= HsEnd);
  assign vs_o        = (v_q >= VsFirst) && (v_q <= VsLast);

endmodule

// File: rtl/arti_pattern_gen.sv
// Test-pattern generator top: samples frame/line settings and registers pixel, blank and sync.
module arti_pattern_gen
  import arti_pattern_gen_pkg::*;
#(
  parameter int unsigned VActive    = V_ACTIVE,
  parameter int unsigned VsStart    = VS_START,
  parameter int unsigned VsEnd      = VS_END,
  parameter int unsigned VTotalNtsc = V_TOTAL_NTSC,
  parameter int unsigned VTotalPal  = V_TOTAL_PAL
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      ce_pix,
  input  logic                      enable,
  input  logic                      colorset,
  input  logic [1:0]                mode,
  input  logic [7:0]                luma,
  arti_pattern_gen_if.master        vid
);

  logic       h_lsb, band_lsb, line_end, frame_end, hbl, vbl, hs, vs, lit;
  logic       pal_q, pal_d;
  mode_e      mode_q, mode_d;
  logic [7:0] luma_q, luma_d, pix_q, pix_d;
  logic       hbl_q, hbl_d, vbl_q, vbl_d, hs_q, hs_d, vs_q, vs_d;

  arti_pattern_timing #(
    .VActive   (VActive),
    .VsStart   (VsStart),
    .VsEnd     (VsEnd),
    .VTotalNtsc(VTotalNtsc),
    .VTotalPal (VTotalPal)
  ) u_timing (
    .clk_i      (clk),
    .rst_ni     (reset_n),
    .ce_pix_i   (ce_pix),
    .pal_i      (pal_q),
    .h_lsb_o    (h_lsb),
    .band_lsb_o (band_lsb),
    .line_end_o (line_end),
    .frame_end_o(frame_end),
    .hbl_o      (hbl),
    .vbl_o      (vbl),
    .hs_o       (hs),
    .vs_o       (vs)
  );

  always_comb begin
    pal_d  = pal_q;
    mode_d = mode_q;
    luma_d = luma_q;
    pix_d  = pix_q;
    hbl_d  = hbl_q;
    vbl_d  = vbl_q;
    hs_d   = hs_q;
    vs_d   = vs_q;
    lit    = 1'b0;

    unique case (mode_q)
      ModeSolid: lit = 1'b1;
      ModeAltA:  lit = ~h_lsb;
      ModeAltB:  lit = h_lsb;
      ModeBars:  lit = ~(h_lsb ^ band_lsb);  // even band -> phase A, odd band -> phase B
      default:   lit = 1'b0;
    endcase

    if (ce_pix) begin
      // The current pixel still uses the old settings; new ones apply from the next h=0.
      if (line_end) begin
        mode_d = mode_e'(mode);
        luma_d = luma;
      end
      if (frame_end) begin
        pal_d = colorset;
      end
      pix_d = (enable && lit && !hbl && !vbl) ? luma_q : 8'd0;
      hbl_d = hbl;
      vbl_d = vbl;
      hs_d  = hs;
      vs_d  = vs;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pal_q  <= 1'b0;
      mode_q <= ModeSolid;
      luma_q <= '0;
      pix_q  <= '0;
      hbl_q  <= 1'b0;
      vbl_q  <= 1'b0;
      hs_q   <= 1'b0;
      vs_q   <= 1'b0;
    end else begin
      pal_q  <= pal_d;
      mode_q <= mode_d;
      luma_q <= luma_d;
      pix_q  <= pix_d;
      hbl_q  <= hbl_d;
      vbl_q  <= vbl_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
    end
  end

  assign vid.r_out   = pix_q;
  assign vid.g_out   = pix_q;
  assign vid.b_out   = pix_q;
  assign vid.hbl_out = hbl_q;
  assign vid.vbl_out = vbl_q;
  assign vid.hs_out  = hs_q;
  assign vid.vs_out  = vs_q;

endmodule

// File: doc/arti_pattern_gen.md
ARTI_PATTERN_GEN -- requirements
Module: arti_pattern_gen

Interface
REQ-001 clk  input  1  system clock; all state on rising edge; one clock domain.
REQ-002 reset_n  input  1  asynchronous, active-low reset.
REQ-003 ce_pix  input  1  pixel enable; all counters and outputs advance only when high.
REQ-004 enable  input  1  0 = pixel outputs forced black; timing keeps running.
REQ-005 colorset  input  1  0 = NTSC frame (262 lines), 1 = PAL frame (312 lines).
REQ-006 mode  input  2  0 solid, 1 alternate phase A, 2 alternate phase B, 3 phase bars.
REQ-007 luma  input  8  grey level of lit pixels, applied to R=G=B.
REQ-008 r_out, g_out, b_out  output  8 each  pixel colour.
REQ-009 hbl_out, vbl_out, hs_out, vs_out  output  1 each  blanking and syncs, active high.

Function
REQ-010 Horizontal counter h SHALL count 0..455 on ce_pix, wrapping 455->0 and incrementing vertical counter v.
REQ-011 v SHALL count 0..V_TOTAL-1 (261 NTSC, 311 PAL), wrapping to 0 together with h 455->0.
REQ-012 hbl_out SHALL be 1 for h in 384..455, else 0; hs_out SHALL be 1 for h in 408..439.
REQ-013 vbl_out SHALL be 1 for v in 240..V_TOTAL-1; vs_out SHALL be 1 for v in 248..250.
REQ-014 All outputs SHALL be registered, valid one ce_pix after the (h,v) they describe; syncs, blanks and pixels stay mutually aligned.
REQ-015 colorset SHALL be sampled only at the frame wrap (h=455, v=V_TOTAL-1 -> 0); mid-frame changes take effect next frame.
REQ-016 mode and luma SHALL be sampled at h=455 (line start); mid-line changes take effect on the next line.
REQ-017 Mode 0: every active pixel = luma.
REQ-018 Mode 1: pixel = luma when h even, 0 when h odd.
REQ-019 Mode 2: pixel = luma when h odd, 0 when h even.
REQ-020 Mode 3: band k = h[8:6]... defined as k = h/48 (0..7); band with k even uses mode-1 rule, k odd uses mode-2 rule.
REQ-021 During hbl or vbl, or when enable=0, r/g/b SHALL be 0; sync/blank outputs unaffected by enable.
REQ-022 luma=0 SHALL yield an all-black active area in every mode (no special case).
REQ-023 ce_pix low SHALL freeze all counters and outputs (hold last value).
REQ-024 Band index SHALL derive from a separate 0..47 sub-counter and 3-bit band counter reset at h=0; no divider.

Reset
REQ-025 reset_n low SHALL asynchronously clear h, v, band counters to 0 and all outputs to 0.
REQ-026 Registered colorset/mode/luma SHALL reset to 0 (NTSC, solid, black).
REQ-027 First ce_pix after reset release SHALL output state for (h=0,v=0) using reset-sampled settings until first line/frame wrap.
REQ-028 Reset asserted mid-frame SHALL abort the frame; no partial sync pulse persists after reset.

Structure
REQ-029 Shared package SHALL hold H_TOTAL=456, H_ACTIVE=384, HS_START=408, HS_END=439, V_ACTIVE=240, VS_START=248, VS_END=250, V_TOTAL_NTSC=262, V_TOTAL_PAL=312, BAND_W=48, and a mode enum.
REQ-030 One sub-module arti_pattern_timing SHALL own h/v counters and sync/blank decode; top level owns sampling and pixel mux.

Verification
REQ-031 Reset, mode=1, luma=0x80, ce_pix every clock -> line 0 pixels 0x80,0x00,0x80,... for h 0..383, then 0 with hbl_out=1 from h=384.
REQ-032 colorset=0 then 1 mid-frame -> current frame vs period 262 lines; following frame 312 lines; hs_out high exactly 32 pixels each line.
REQ-033 mode=3, luma=0xFF -> h=0 lit, h=48 dark, h=49 lit, h=96 lit; output sequence matches band rule across all 8 bands.
REQ-034 mode switched 1->2 at h=100 -> remainder of line stays phase A; next line h=0 pixel=0, h=1 pixel=luma.
REQ-035 ce_pix asserted 1 clock in 3 -> outputs change only on enabled clocks; enable=0 -> r/g/b=0 while hs_out/vs_out timing unchanged.
REQ-036 reset_n pulsed low at v=100 -> outputs 0 immediately; after release next output corresponds to h=0, v=0.
